// File: rtl/cv32e40p_core_v_xif_pkg.sv
// CORE-V-XIF struct types shared between the core and its coprocessors.
package cv32e40p_core_v_xif_pkg;

  parameter int X_DATAWIDTH = 32;
  parameter int X_NUM_RS    = 3;
  parameter int X_ID_WIDTH  = 4;
  parameter int X_RFR_WIDTH = 32;
  parameter int X_RFW_WIDTH = 32;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [1:0]                           mode;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
    logic [5:0]                           ecs;
    logic                                 ecs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic ecswrite;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]              id;
    logic [X_RFW_WIDTH-1:0]             data;
    logic [4:0]                         rd;
    logic [X_RFW_WIDTH/X_DATAWIDTH-1:0] we;
    logic [2:0]                         ecswe;
    logic [5:0]                         ecsdata;
    logic                               exc;
    logic [5:0]                         exccode;
  } x_result_t;

endpackage

// File: rtl/cv32e40p_xif_alu_coproc.sv
// XIF coprocessor for custom-0 ADD/SUB/XOR/MAC: results computed at issue,
// held in an in-order buffer until commit/kill, then returned in issue order.
module cv32e40p_xif_alu_coproc
  import cv32e40p_core_v_xif_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter logic [6:0]  OPCODE = 7'h0B
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          x_issue_valid_i,
  output logic          x_issue_ready_o,
  input  x_issue_req_t  x_issue_req_i,
  output x_issue_resp_t x_issue_resp_o,
  input  logic          x_commit_valid_i,
  input  x_commit_t     x_commit_i,
  output logic          x_result_valid_o,
  input  logic          x_result_ready_i,
  output x_result_t     x_result_o,
  output logic          busy_o,
  output logic          protocol_err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    logic                  vld;
    logic                  committed;
    logic                  killed;
    logic [X_ID_WIDTH-1:0] id;
    logic [4:0]            rd;
    logic [31:0]           data;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, cptr_q, cptr_d;
  logic [PW:0]        count_q, count_d;
  logic               err_q, err_d;

  logic [2:0]  funct3;
  logic        op_ok, rs_ok, push, pop, commit_ok;
  logic [31:0] rs0, rs1, rs2, alu_res;
  entry_t      head_ent, cptr_ent;
  logic        unused_req;

  assign funct3 = x_issue_req_i.instr[14:12];
  assign rs0    = x_issue_req_i.rs[0];
  assign rs1    = x_issue_req_i.rs[1];
  assign rs2    = x_issue_req_i.rs[2];
  assign op_ok  = (x_issue_req_i.instr[6:0] == OPCODE) &&
                  (x_issue_req_i.instr[31:25] == 7'd0) && !funct3[2];
  assign rs_ok  = x_issue_req_i.rs_valid[0] && x_issue_req_i.rs_valid[1] &&
                  ((funct3 != 3'd3) || x_issue_req_i.rs_valid[2]);

  assign unused_req = ^{x_issue_req_i.mode, x_issue_req_i.ecs,
                        x_issue_req_i.ecs_valid, x_issue_req_i.instr[24:15]};

  always_comb begin
    alu_res = '0;
    case (funct3[1:0])
      2'd0:    alu_res = rs0 + rs1;
      2'd1:    alu_res = rs0 - rs1;
      2'd2:    alu_res = rs0 ^ rs1;
      default: alu_res = rs0 * rs1 + rs2;
    endcase
  end

  // Rejected encodings always handshake so the core is never stalled by them.
  assign x_issue_ready_o = !op_ok || ((count_q < DEPTH_C) && rs_ok);

  always_comb begin
    x_issue_resp_o           = '0;
    x_issue_resp_o.accept    = op_ok;
    x_issue_resp_o.writeback = op_ok;
  end

  assign head_ent = ent_q[head_q];
  assign cptr_ent = ent_q[cptr_q];

  assign push      = x_issue_valid_i && x_issue_ready_o && op_ok;
  assign pop       = head_ent.vld &&
                     (head_ent.killed || (head_ent.committed && x_result_ready_i));
  assign commit_ok = x_commit_valid_i && cptr_ent.vld && !cptr_ent.committed &&
                     !cptr_ent.killed && (cptr_ent.id == x_commit_i.id);

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cptr_d  = cptr_q;
    err_d   = err_q;
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    if (pop) begin
      ent_d[head_q] = '0;
      head_d        = head_q + 1'b1;
    end
    if (x_commit_valid_i) begin
      if (commit_ok) begin
        if (x_commit_i.commit_kill) ent_d[cptr_q].killed = 1'b1;
        else                        ent_d[cptr_q].committed = 1'b1;
        cptr_d = cptr_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (push) begin
      ent_d[tail_q].vld       = 1'b1;
      ent_d[tail_q].committed = 1'b0;
      ent_d[tail_q].killed    = 1'b0;
      ent_d[tail_q].id        = x_issue_req_i.id;
      ent_d[tail_q].rd        = x_issue_req_i.instr[11:7];
      ent_d[tail_q].data      = alu_res;
      tail_d                  = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cptr_q  <= cptr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign x_result_valid_o = head_ent.vld && head_ent.committed;

  always_comb begin
    x_result_o = '0;
    if (x_result_valid_o) begin
      x_result_o.id   = head_ent.id;
      x_result_o.data = head_ent.data;
      x_result_o.rd   = head_ent.rd;
      x_result_o.we   = (head_ent.rd != 5'd0);
    end
  end

  assign busy_o         = (count_q != '0);
  assign protocol_err_o = err_q;

endmodule
